back_end: RTL
=============

Name: back_end

Overview:
- Output-side controller for the accelerator datapath.
- Drains the result FIFO, which is filled by the compute front end, and presents the words as an AXI4-Stream master to the host-side DMA.
- Transfers a programmed word count, marks the final word with tlast, then pulses done.
- Uses a 2-entry output buffer that absorbs the 1-cycle FIFO read latency, so it sustains 1 word/cycle under continuous tready.

Parameters:
- DATA_WIDTH, 32, width of FIFO data and m_axis_tdata.
- LEN_WIDTH, 16, width of the transfer length. Maximum transfer is 2^LEN_WIDTH-1 words.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse that begins a transfer; sampled only in IDLE.
- len  in  LEN_WIDTH  number of words to send; sampled when start is accepted.
- empty  in  1  result FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after rden.
- rden  out  1  FIFO read strobe.
- m_axis_tdata  out  DATA_WIDTH  stream data (registered).
- m_axis_tvalid  out  1  stream valid (registered).
- m_axis_tready  in  1  stream ready from the sink.
- m_axis_tlast  out  1  high with tvalid on the final word of the transfer.
- busy  out  1  high from the cycle after start is accepted through the done cycle inclusive.
- done  out  1  1-cycle pulse after the final handshake.

Behaviour:
- Reset: synchronous, active-high. While areset is high at a clock edge:
  - state goes to IDLE;
  - rden, m_axis_tvalid, m_axis_tlast, busy and done are 0;
  - m_axis_tdata is 0;
  - buffer occupancy, in-flight flag, to_issue and to_send are 0.
- Reset mid-transfer: any in-flight FIFO word is discarded, not buffered.
- Internal counters and flags:
  - to_issue: reads still to be issued.
  - to_send: handshakes still to complete.
  - occ: buffer occupancy, 0..2.
  - inflight: rden was asserted last cycle.
  - pop: m_axis_tvalid && m_axis_tready.
- States: IDLE, RUN, LAST, DONE.
- IDLE:
  - start && len!=0 -> RUN; load to_issue = to_send = len.
  - start && len==0 -> DONE. No words are sent and tvalid is never asserted.
  - Otherwise stay in IDLE; rden = 0.
- RUN:
  - rden = !empty && to_issue!=0 && (occ + inflight - pop) < 2. This is combinational from state, empty, counters and tready.
  - Each rden decrements to_issue.
  - Transition to LAST when to_issue reaches 0, i.e. on the cycle after the last rden.
- LAST:
  - rden = 0.
  - Wait for the handshake with to_send==1, then go to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 1, tvalid = 0.
  - Next state is IDLE.
- Buffer:
  - Returning FIFO data (cycle after rden) is written to the head register if it will be empty after this cycle's pop; otherwise it goes to the skid register.
  - On pop, the skid register moves to the head.
  - m_axis_tvalid = occ!=0; m_axis_tdata = head register.
- AXI rules:
  - Once tvalid is high, tvalid, tdata and tlast stay stable until the handshake completes.
  - tvalid never depends combinationally on tready.
- tlast: high exactly while tvalid is high and to_send==1.
- Each handshake decrements to_send.
- Simultaneous events in one cycle (FIFO return, pop, new rden) are all legal; occupancy never exceeds 2.
- Empty FIFO: rden is held at 0. This stalls only issue; buffered words still drain.
- Backpressure: tready low indefinitely is legal. With occ==2, rden stays 0.
- start while not IDLE is ignored, and len is not re-sampled.
- Throughput: 1 word/cycle while tready=1 and !empty.
- Latency: first tvalid appears 3 cycles after the start cycle:
  - start cycle +1: RUN, rden;
  - +2: data captured;
  - +3: tvalid.

Decomposition:
- Shared package (accel_pkg):
  - back_end state encoding (IDLE=2'd0, RUN=2'd1, LAST=2'd2, DONE=2'd3), kept alongside the front_end state constants;
  - default DATA_WIDTH and LEN_WIDTH.
- One sub-module: axis_out_buf, the 2-entry head/skid output buffer with occupancy. The FSM and counters stay in back_end.

Test Plan:
- Streaming: len=4, FIFO holds 0xA0..0xA3, tready=1. Expect:
  - tvalid high for 4 consecutive cycles, data A0,A1,A2,A3;
  - tlast only with A3;
  - done one cycle after the A3 handshake;
  - rden asserted exactly 4 times.
- Backpressure: len=8, tready toggles 1,0,0,1,... Expect:
  - all 8 words in order, none lost or duplicated;
  - tdata/tvalid/tlast stable during each tready=0;
  - rden never asserted while occ==2.
- Starved FIFO: len=3, empty=1 for 5 cycles after start, then data 0x11,0x22,0x33 available. Expect:
  - no rden during empty;
  - words 11,22,33 delivered with tlast on 33;
  - busy high throughout.
- Zero length: start with len=0. Expect:
  - done pulses the cycle after start, busy high for that cycle;
  - tvalid and rden stay 0.
- Reset mid-transfer: len=16, areset asserted after 5 handshakes. Expect:
  - next cycle tvalid=0, busy=0, done=0, state IDLE;
  - a new start with len=2 sends exactly 2 words with tlast on the 2nd.
- Start ignored when busy: pulse start with len=9 during a len=4 transfer. Expect exactly 4 words and a single done pulse.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: FSM state encodings and default datapath widths.
package accel_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    FE_IDLE    = 2'd0,
    FE_LOAD    = 2'd1,
    FE_COMPUTE = 2'd2,
    FE_FLUSH   = 2'd3
  } fe_state_e;

  typedef enum logic [1:0] {
    BE_IDLE = 2'd0,
    BE_RUN  = 2'd1,
    BE_LAST = 2'd2,
    BE_DONE = 2'd3
  } be_state_e;

endpackage

// File: rtl/axis_out_buf.sv
// Two-entry head/skid output buffer; head drives the stream, skid absorbs the
// word returning from the FIFO while the head is still waiting for a handshake.
module axis_out_buf
  import accel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [1:0]            occ_next_c,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] skid;
  logic [1:0]            occ_after_pop;

  always_comb begin
    occ_after_pop = occ - {1'b0, pop};
    occ_next_c    = occ_after_pop + {1'b0, wr};
  end

  // A returning word lands in head only if head is free once this pop retires.
  always_ff @(posedge aclk) begin
    if (areset) begin
      occ   <= 2'd0;
      valid <= 1'b0;
      head  <= '0;
      skid  <= '0;
    end else begin
      occ   <= occ_next_c;
      valid <= (occ_next_c != 2'd0);
      if (pop && (occ == 2'd2)) head <= skid;
      if (wr) begin
        if (occ_after_pop == 2'd0) head <= wdata;
        else                       skid <= wdata;
      end
    end
  end

endmodule

// File: rtl/back_end.sv
// Output-side controller: drains the result FIFO into an AXI4-Stream master for
// a programmed word count, flags the final word with tlast, then pulses done.
module back_end
  import accel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  rden,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done
);

  be_state_e            state, state_next;
  logic [LEN_WIDTH-1:0] to_issue, to_send, to_send_next;
  logic                 inflight, pop, accept;
  logic [1:0]           occ, occ_next;
  logic [2:0]           pending;

  assign pop     = m_axis_tvalid && m_axis_tready;
  assign accept  = (state == BE_IDLE) && start;
  // Words that will occupy the buffer after this cycle, excluding a new read.
  assign pending = 3'(occ) + 3'(inflight) - 3'(pop);

  always_ff @(posedge aclk) begin
    if (areset) state <= BE_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    rden       = 1'b0;
    case (state)
      BE_IDLE: begin
        if (start) state_next = (len != '0) ? BE_RUN : BE_DONE;
      end
      BE_RUN: begin
        rden = !empty && (to_issue != '0) && (pending < 3'd2);
        if (rden && (to_issue == LEN_WIDTH'(1))) state_next = BE_LAST;
      end
      BE_LAST: begin
        if (pop && (to_send == LEN_WIDTH'(1))) state_next = BE_DONE;
      end
      BE_DONE: state_next = BE_IDLE;
      default: state_next = BE_IDLE;
    endcase
  end

  always_comb begin
    to_send_next = to_send;
    if (accept)   to_send_next = len;
    else if (pop) to_send_next = to_send - LEN_WIDTH'(1);
  end

  // tlast is precomputed so it registers alongside the word it qualifies.
  always_ff @(posedge aclk) begin
    if (areset) begin
      to_issue     <= '0;
      to_send      <= '0;
      inflight     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      m_axis_tlast <= 1'b0;
    end else begin
      inflight <= rden;
      to_send  <= to_send_next;
      if (accept)    to_issue <= len;
      else if (rden) to_issue <= to_issue - LEN_WIDTH'(1);
      busy         <= (state_next != BE_IDLE);
      done         <= (state_next == BE_DONE);
      m_axis_tlast <= (occ_next != 2'd0) && (to_send_next == LEN_WIDTH'(1));
    end
  end

  axis_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .aclk      (aclk),
    .areset    (areset),
    .wr        (inflight),
    .wdata     (fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .occ_next_c(occ_next),
    .valid     (m_axis_tvalid),
    .head      (m_axis_tdata)
  );

endmodule
